lsu_ac_arb: RTL
===============

Name: lsu_ac_arb

Overview:
- Arbitrates between two address-check (AC) stage requesters: port 0 is the RCU issue path, port 1 is the LSQ replay path.
- Registers the granted request into a single-entry AC slot. That slot drives the combinational misalign checker.
- On a checker exception, the slot retires the entry and reports it to the RCU. Otherwise it hands the entry to the next LSU stage with a valid/ready handshake.

Parameters:
- VIRTUAL_ADDR_LEN, 39, width of the virtual address
- LS_OPCODE_WIDTH, 4, width of the load/store opcode
- EXCEPTION_CAUSE_WIDTH, 4, width of the exception cause
- ROB_INDEX_WIDTH, 6, width of the ROB tag

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush_i  in  1  pipeline flush
- req0_vld_i, req1_vld_i  in  1 each  request valid
- req0_ls_i, req1_ls_i  in  1 each  1 = store, 0 = load
- req0_opcode_i, req1_opcode_i  in  LS_OPCODE_WIDTH each  opcode
- req0_addr_i, req1_addr_i  in  VIRTUAL_ADDR_LEN each  address from AGU
- req0_rob_idx_i, req1_rob_idx_i  in  ROB_INDEX_WIDTH each  ROB tag
- req0_rdy_o, req1_rdy_o  out  1 each  request accepted this cycle
- ac_vld_o  out  1  slot occupied; feeds the checker valid
- ac_ls_o  out  1  slot ls bit
- ac_opcode_o  out  LS_OPCODE_WIDTH  slot opcode
- ac_addr_o  out  VIRTUAL_ADDR_LEN  slot address
- ac_rob_idx_o  out  ROB_INDEX_WIDTH  slot ROB tag
- ac_exception_vld_i  in  1  checker exception on the slot contents
- ac_ecause_i  in  EXCEPTION_CAUSE_WIDTH  checker cause
- pass_vld_o  out  1  slot valid and no exception, toward next stage
- pass_rdy_i  in  1  next stage ready
- exc_vld_o  out  1  registered one-cycle exception report
- exc_rob_idx_o  out  ROB_INDEX_WIDTH  tag of the faulting entry
- exc_cause_o  out  EXCEPTION_CAUSE_WIDTH  cause of the fault

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rstn is synchronous and active-low.
- Reset values: slot empty, so ac_vld_o=0. All ac_* payloads, exc_vld_o, exc_rob_idx_o, exc_cause_o = 0. Round-robin pointer rr=0 (port 0 preferred).
- Slot states:
  - EMPTY to FULL on a grant.
  - FULL drains when drain = ac_vld_o & (ac_exception_vld_i | pass_rdy_i). The exception path drains regardless of pass_rdy_i.
  - FULL plus drain plus a new grant in the same cycle stays FULL with the new payload. This gives back-to-back throughput of 1 per cycle.
- pass_vld_o = ac_vld_o & ~ac_exception_vld_i & ~flush_i.
- Grant eligibility: can_accept = ~flush_i & (~ac_vld_o | drain).
- Arbitration:
  - Only one requester valid: it is granted if can_accept.
  - Both valid: port rr wins.
  - reqN_rdy_o = can_accept & granted(N); this signal is combinational.
  - A grant is a valid&rdy handshake; the payload is latched next edge.
  - After a grant with both ports requesting, rr becomes the non-granted port. With a single requester, rr is unchanged.
- Exception report:
  - When ac_vld_o & ac_exception_vld_i & ~flush_i, the next cycle drives exc_vld_o=1 with exc_rob_idx_o=ac_rob_idx_o and exc_cause_o=ac_ecause_i.
  - Otherwise exc_vld_o=0. exc payloads hold their last value.
- Flush:
  - Next cycle the slot is empty. No grant occurs in the flush cycle and exc_vld_o=0 next cycle.
  - pass_vld_o is 0 during the flush cycle.
  - Flush has priority over exception, drain and grant. rr is not changed.
- Stall: FULL with no drain holds all ac_* outputs stable and both rdy=0.
- rstn has priority over flush_i. Reset mid-stream discards the slot with no exception report.

Optional Feature:
- Macro: LSU_AC_ARB_REPLAY_PRIO_EN
- Defined: fixed priority, port 1 (replay) always wins when both ports request. rr is not used and may be removed.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Both ports valid for 4 cycles, pass_rdy_i=1 -> grants alternate 0,1,0,1. ac_vld_o=1 from cycle 2. Throughput 1 per cycle.
- Port 0 load, addr 0x1002, rob 5, pass_rdy_i=0; checker asserts ac_exception_vld_i with cause 4 -> slot drains despite pass_rdy_i=0. Next cycle exc_vld_o=1, exc_rob_idx_o=5, exc_cause_o=4. pass_vld_o stays 0.
- Slot FULL, pass_rdy_i=0 for 3 cycles, port 1 valid -> req1_rdy_o=0 and ac_addr_o stable for 3 cycles. pass_rdy_i=1 in cycle 4 -> same-cycle grant of port 1, payload swapped next edge.
- flush_i coincident with slot exception and port 0 valid -> next cycle ac_vld_o=0, exc_vld_o=0, req0_rdy_o=0 during the flush cycle.
- rstn=0 while slot FULL -> next edge all outputs 0, rr=0. First request after reset, with both ports valid, grants port 0 (port 1 with LSU_AC_ARB_REPLAY_PRIO_EN).
- With LSU_AC_ARB_REPLAY_PRIO_EN defined, both ports valid for 3 cycles -> port 1 granted every cycle, req0_rdy_o=0 throughout.

Source files
------------

// File: rtl/lsu_ac_arb_if.sv
// lsu_ac_arb_if: bundles every signal between the AC-stage arbiter and its
// surroundings (two requesters, the misalign checker, the next LSU stage and
// the RCU exception report).
//   slave  : the arbiter side (lsu_ac_arb)
//   master : the environment side (requesters, checker, next stage, RCU)
interface lsu_ac_arb_if #(
  parameter int VIRTUAL_ADDR_LEN      = 39,
  parameter int LS_OPCODE_WIDTH       = 4,
  parameter int EXCEPTION_CAUSE_WIDTH = 4,
  parameter int ROB_INDEX_WIDTH       = 6
);
  logic                             flush_i;
  logic                             req0_vld_i, req1_vld_i;
  logic                             req0_ls_i, req1_ls_i;
  logic [LS_OPCODE_WIDTH-1:0]       req0_opcode_i, req1_opcode_i;
  logic [VIRTUAL_ADDR_LEN-1:0]      req0_addr_i, req1_addr_i;
  logic [ROB_INDEX_WIDTH-1:0]       req0_rob_idx_i, req1_rob_idx_i;
  logic                             req0_rdy_o, req1_rdy_o;
  logic                             ac_vld_o;
  logic                             ac_ls_o;
  logic [LS_OPCODE_WIDTH-1:0]       ac_opcode_o;
  logic [VIRTUAL_ADDR_LEN-1:0]      ac_addr_o;
  logic [ROB_INDEX_WIDTH-1:0]       ac_rob_idx_o;
  logic                             ac_exception_vld_i;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] ac_ecause_i;
  logic                             pass_vld_o;
  logic                             pass_rdy_i;
  logic                             exc_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]       exc_rob_idx_o;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] exc_cause_o;

  modport slave (
    input  flush_i,
    input  req0_vld_i, req1_vld_i, req0_ls_i, req1_ls_i,
    input  req0_opcode_i, req1_opcode_i, req0_addr_i, req1_addr_i,
    input  req0_rob_idx_i, req1_rob_idx_i,
    output req0_rdy_o, req1_rdy_o,
    output ac_vld_o, ac_ls_o, ac_opcode_o, ac_addr_o, ac_rob_idx_o,
    input  ac_exception_vld_i, ac_ecause_i,
    output pass_vld_o,
    input  pass_rdy_i,
    output exc_vld_o, exc_rob_idx_o, exc_cause_o
  );

  modport master (
    output flush_i,
    output req0_vld_i, req1_vld_i, req0_ls_i, req1_ls_i,
    output req0_opcode_i, req1_opcode_i, req0_addr_i, req1_addr_i,
    output req0_rob_idx_i, req1_rob_idx_i,
    input  req0_rdy_o, req1_rdy_o,
    input  ac_vld_o, ac_ls_o, ac_opcode_o, ac_addr_o, ac_rob_idx_o,
    output ac_exception_vld_i, ac_ecause_i,
    input  pass_vld_o,
    output pass_rdy_i,
    input  exc_vld_o, exc_rob_idx_o, exc_cause_o
  );
endinterface

// File: rtl/lsu_ac_arb.sv
// lsu_ac_arb: two-port arbiter feeding a single-entry address-check slot.
// Port 0 is the RCU issue path, port 1 the LSQ replay path. The slot drives
// the combinational misalign checker; a faulting entry retires with a
// one-cycle registered report to the RCU, otherwise it is handed to the next
// stage over pass_vld_o/pass_rdy_i. Drain and refill in the same cycle give
// one entry per cycle.
// Ports:
//   clk   - clock
//   rstn  - synchronous active-low reset
//   bus   - lsu_ac_arb_if.slave (requests, slot outputs, checker, pass, exc)
// Build option:
//   LSU_AC_ARB_REPLAY_PRIO_EN - when defined, port 1 wins whenever both ports
//   request; otherwise the two ports alternate round-robin.
module lsu_ac_arb #(
  parameter int VIRTUAL_ADDR_LEN      = 39,
  parameter int LS_OPCODE_WIDTH       = 4,
  parameter int EXCEPTION_CAUSE_WIDTH = 4,
  parameter int ROB_INDEX_WIDTH       = 6
) (
  input logic         clk,
  input logic         rstn,
  lsu_ac_arb_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t state, state_nxt;

  logic                             full;
  logic                             drain;
  logic                             can_accept;
  logic                             sel1;   // port 1 wins if it is granted
  logic                             gnt0, gnt1, grant;
  logic                             exc_fire;

  logic                             slot_ls;
  logic [LS_OPCODE_WIDTH-1:0]       slot_opcode;
  logic [VIRTUAL_ADDR_LEN-1:0]      slot_addr;
  logic [ROB_INDEX_WIDTH-1:0]       slot_rob;
  logic                             exc_vld;
  logic [ROB_INDEX_WIDTH-1:0]       exc_rob;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] exc_cause;

  assign full  = (state == FULL);
  // Exceptions retire the entry without waiting for the next stage.
  assign drain = full & (bus.ac_exception_vld_i | bus.pass_rdy_i);
  assign can_accept = ~bus.flush_i & (~full | drain);

`ifdef LSU_AC_ARB_REPLAY_PRIO_EN
  assign sel1 = bus.req1_vld_i;
`else
  logic rr;  // port preferred when both request
  assign sel1 = bus.req1_vld_i & (~bus.req0_vld_i | rr);

  // Only contested grants move the pointer; it then favours the loser.
  always_ff @(posedge clk) begin
    if (!rstn)                                        rr <= 1'b0;
    else if (grant & bus.req0_vld_i & bus.req1_vld_i) rr <= gnt0;
  end
`endif

  assign gnt1  = can_accept & sel1;
  assign gnt0  = can_accept & bus.req0_vld_i & ~sel1;
  assign grant = gnt0 | gnt1;
  assign exc_fire = full & bus.ac_exception_vld_i & ~bus.flush_i;

  // Slot FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Slot FSM: next state (flush beats refill, refill beats drain)
  always_comb begin
    state_nxt = state;
    if (bus.flush_i)  state_nxt = EMPTY;
    else if (grant)   state_nxt = FULL;
    else if (drain)   state_nxt = EMPTY;
  end

  // Slot FSM: outputs
  always_comb begin
    bus.ac_vld_o   = full;
    bus.pass_vld_o = full & ~bus.ac_exception_vld_i & ~bus.flush_i;
    bus.req0_rdy_o = gnt0;
    bus.req1_rdy_o = gnt1;
  end

  // Payload is only written on a grant, so it holds through stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_ls     <= 1'b0;
      slot_opcode <= '0;
      slot_addr   <= '0;
      slot_rob    <= '0;
    end else if (grant) begin
      slot_ls     <= sel1 ? bus.req1_ls_i      : bus.req0_ls_i;
      slot_opcode <= sel1 ? bus.req1_opcode_i  : bus.req0_opcode_i;
      slot_addr   <= sel1 ? bus.req1_addr_i    : bus.req0_addr_i;
      slot_rob    <= sel1 ? bus.req1_rob_idx_i : bus.req0_rob_idx_i;
    end
  end

  // Exception report: valid for one cycle, payload sticky.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exc_vld   <= 1'b0;
      exc_rob   <= '0;
      exc_cause <= '0;
    end else begin
      exc_vld <= exc_fire;
      if (exc_fire) begin
        exc_rob   <= slot_rob;
        exc_cause <= bus.ac_ecause_i;
      end
    end
  end

  assign bus.ac_ls_o       = slot_ls;
  assign bus.ac_opcode_o   = slot_opcode;
  assign bus.ac_addr_o     = slot_addr;
  assign bus.ac_rob_idx_o  = slot_rob;
  assign bus.exc_vld_o     = exc_vld;
  assign bus.exc_rob_idx_o = exc_rob;
  assign bus.exc_cause_o   = exc_cause;

endmodule
